// File: rtl/load_store_buffer_pkg.sv
// Shared definitions for the load/store buffer: widths, op-id encoding,
// queue entry layout and the operand wakeup / load-extension helpers.
package load_store_buffer_pkg;

  localparam int XLEN          = 32;
  localparam int ROB_W         = 4;
  localparam int OP_W          = 6;
  localparam int DEFAULT_DEPTH = 16;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_LB  = 6'd1;
  localparam op_t OP_LH  = 6'd2;
  localparam op_t OP_LW  = 6'd3;
  localparam op_t OP_LBU = 6'd4;
  localparam op_t OP_LHU = 6'd5;
  localparam op_t OP_SB  = 6'd6;
  localparam op_t OP_SH  = 6'd7;
  localparam op_t OP_SW  = 6'd8;

  // When rdy is low, val carries the producer ROB id in its low ROB_W bits.
  typedef struct packed {
    logic            rdy;
    logic [XLEN-1:0] val;
  } operand_t;

  typedef struct packed {
    op_t             op;
    logic [ROB_W-1:0] rob_id;
    operand_t        rs1;
    operand_t        rs2;
    logic [XLEN-1:0] imm;
  } entry_t;

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] id;
    logic [XLEN-1:0]  val;
  } bcast_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_WAIT,
    ST_STORE_WAIT
  } state_t;

  function automatic logic is_load(input op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input op_t op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic [XLEN-1:0] extend(input op_t op, input logic [XLEN-1:0] raw);
    case (op)
      OP_LB:   return {{24{raw[7]}}, raw[7:0]};
      OP_LH:   return {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  return {24'b0, raw[7:0]};
      OP_LHU:  return {16'b0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // The commit broadcast wins if both buses carry the same tag; values agree anyway.
  function automatic operand_t wake(input operand_t o, input bcast_t a, input bcast_t b);
    operand_t w;
    w = o;
    if (!o.rdy) begin
      if (a.valid && o.val[ROB_W-1:0] == a.id)      w = '{rdy: 1'b1, val: a.val};
      else if (b.valid && o.val[ROB_W-1:0] == b.id) w = '{rdy: 1'b1, val: b.val};
    end
    return w;
  endfunction

endpackage

// File: rtl/load_store_buffer_if.sv
// Bus bundle around the load/store buffer: decoder push, ROB broadcast and
// commit, memory-controller read port and the result/wakeup bus.
interface load_store_buffer_if;
  import load_store_buffer_pkg::*;

  logic             id_valid;
  logic [OP_W-1:0]  id_op;
  logic [ROB_W-1:0] id_rob_id;
  logic             id_rs1_ready;
  logic             id_rs2_ready;
  logic [XLEN-1:0]  id_rs1_val;
  logic [XLEN-1:0]  id_rs2_val;
  logic [XLEN-1:0]  id_imm;
  logic             full;

  logic             rob_bc_valid;
  logic [ROB_W-1:0] rob_bc_id;
  logic [XLEN-1:0]  rob_bc_val;
  logic             head_store_commit;
  logic [ROB_W-1:0] head_commit_rob_id;
  logic             rollback;

  logic             mc_req;
  logic [XLEN-1:0]  mc_addr;
  logic [OP_W-1:0]  mc_op;
  logic             mc_done;
  logic [XLEN-1:0]  mc_data;

  logic             res_valid;
  logic [ROB_W-1:0] res_rob_id;
  logic [XLEN-1:0]  res_val;
  logic [XLEN-1:0]  res_addr;

  modport slave (
    input  id_valid, id_op, id_rob_id, id_rs1_ready, id_rs2_ready,
           id_rs1_val, id_rs2_val, id_imm,
           rob_bc_valid, rob_bc_id, rob_bc_val,
           head_store_commit, head_commit_rob_id, rollback,
           mc_done, mc_data,
    output full, mc_req, mc_addr, mc_op,
           res_valid, res_rob_id, res_val, res_addr
  );

  modport master (
    output id_valid, id_op, id_rob_id, id_rs1_ready, id_rs2_ready,
           id_rs1_val, id_rs2_val, id_imm,
           rob_bc_valid, rob_bc_id, rob_bc_val,
           head_store_commit, head_commit_rob_id, rollback,
           mc_done, mc_data,
    input  full, mc_req, mc_addr, mc_op,
           res_valid, res_rob_id, res_val, res_addr
  );

endinterface

// File: rtl/load_store_buffer_load_extend.sv
// Right-aligned memory read data to register value: sign or zero extension by op.
module lsb_load_extend
  import load_store_buffer_pkg::*;
(
  input  op_t             op,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data
);

  assign data = extend(op, raw);

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue: waits for operands, issues loads from the head
// to memory, reports stores to the ROB and pops them on commit.
module load_store_buffer
  import load_store_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input logic              clk,
  input logic              rst_n,
  input logic              rdy,
  load_store_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_GUARD = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0] CNT_FULL  = (PTR_W+1)'(DEPTH);

  entry_t          q [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]  count;
  state_t          state;

  entry_t          head_e, push_e;
  bcast_t          rob_bc, res_bc;
  logic            push_ok, pop, ld_go, st_go;
  logic [XLEN-1:0] head_addr, ld_data;

  assign rob_bc    = '{valid: bus.rob_bc_valid, id: bus.rob_bc_id, val: bus.rob_bc_val};
  assign res_bc    = '{valid: bus.res_valid, id: bus.res_rob_id, val: bus.res_val};
  assign head_e    = q[head];
  assign head_addr = head_e.rs1.val + head_e.imm;
  // The decoder sees full a cycle late, so one slot beyond the flag is still usable.
  assign bus.full  = (count >= CNT_GUARD);
  assign push_ok   = bus.id_valid && (count < CNT_FULL);

  assign push_e = '{
    op:     bus.id_op,
    rob_id: bus.id_rob_id,
    rs1:    wake('{rdy: bus.id_rs1_ready, val: bus.id_rs1_val}, rob_bc, res_bc),
    rs2:    wake('{rdy: bus.id_rs2_ready, val: bus.id_rs2_val}, rob_bc, res_bc),
    imm:    bus.id_imm
  };

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path infers a latch.
    ld_go = 1'b0;
    st_go = 1'b0;
    pop   = 1'b0;
    if (state == ST_IDLE && count != '0) begin
      ld_go = is_load(head_e.op) && head_e.rs1.rdy;
      st_go = is_store(head_e.op) && head_e.rs1.rdy && head_e.rs2.rdy;
    end
    case (state)
      ST_LOAD_WAIT:  pop = bus.mc_done;
      ST_STORE_WAIT: pop = bus.head_store_commit && (bus.head_commit_rob_id == head_e.rob_id);
      default:       pop = 1'b0;
    endcase
  end

  lsb_load_extend u_load_extend (
    .op   (bus.mc_op),
    .raw  (bus.mc_data),
    .data (ld_data)
  );

  // NOTE: entry storage has no reset; count and the pointers alone decide which slots are live.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i].rs1 <= wake(q[i].rs1, rob_bc, res_bc);
        q[i].rs2 <= wake(q[i].rs2, rob_bc, res_bc);
      end
      if (push_ok && !bus.rollback) q[tail] <= push_e;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      state          <= ST_IDLE;
      bus.mc_req     <= 1'b0;
      bus.mc_addr    <= '0;
      bus.mc_op      <= '0;
      bus.res_valid  <= 1'b0;
      bus.res_rob_id <= '0;
      bus.res_val    <= '0;
      bus.res_addr   <= '0;
    end else if (rdy) begin
      bus.res_valid <= 1'b0;
      if (bus.rollback) begin
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        state      <= ST_IDLE;
        bus.mc_req <= 1'b0;
      end else begin
        if (push_ok) tail <= tail + 1'b1;
        if (pop)     head <= head + 1'b1;
        count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
        case (state)
          ST_IDLE: begin
            if (ld_go) begin
              bus.mc_req  <= 1'b1;
              bus.mc_addr <= head_addr;
              bus.mc_op   <= head_e.op;
              state       <= ST_LOAD_WAIT;
            end else if (st_go) begin
              bus.res_valid  <= 1'b1;
              bus.res_rob_id <= head_e.rob_id;
              bus.res_val    <= head_e.rs2.val;
              bus.res_addr   <= head_addr;
              state          <= ST_STORE_WAIT;
            end
          end
          ST_LOAD_WAIT: begin
            if (bus.mc_done) begin
              bus.mc_req     <= 1'b0;
              bus.res_valid  <= 1'b1;
              bus.res_rob_id <= head_e.rob_id;
              bus.res_val    <= ld_data;
              bus.res_addr   <= bus.mc_addr;
              state          <= ST_IDLE;
            end
          end
          ST_STORE_WAIT: begin
            if (pop) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed self-checking bench for load_store_buffer with hand-computed expectations.
module tb_load_store_buffer;
  import load_store_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  load_store_buffer_if bus ();

  load_store_buffer #(.DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_valid           = 1'b0;
    bus.id_op              = '0;
    bus.id_rob_id          = '0;
    bus.id_rs1_ready       = 1'b0;
    bus.id_rs2_ready       = 1'b0;
    bus.id_rs1_val         = '0;
    bus.id_rs2_val         = '0;
    bus.id_imm             = '0;
    bus.rob_bc_valid       = 1'b0;
    bus.rob_bc_id          = '0;
    bus.rob_bc_val         = '0;
    bus.head_store_commit  = 1'b0;
    bus.head_commit_rob_id = '0;
    bus.rollback           = 1'b0;
    bus.mc_done            = 1'b0;
    bus.mc_data            = '0;
  endtask

  task automatic set_push(input op_t op, input logic [3:0] rob, input logic r1_rdy,
                          input logic [31:0] r1, input logic r2_rdy, input logic [31:0] r2,
                          input logic [31:0] imm);
    bus.id_valid     = 1'b1;
    bus.id_op        = op;
    bus.id_rob_id    = rob;
    bus.id_rs1_ready = r1_rdy;
    bus.id_rs1_val   = r1;
    bus.id_rs2_ready = r2_rdy;
    bus.id_rs2_val   = r2;
    bus.id_imm       = imm;
  endtask

  task automatic push(input op_t op, input logic [3:0] rob, input logic r1_rdy,
                      input logic [31:0] r1, input logic r2_rdy, input logic [31:0] r2,
                      input logic [31:0] imm);
    set_push(op, rob, r1_rdy, r1, r2_rdy, r2, imm);
    tick();
    bus.id_valid = 1'b0;
  endtask

  // Push a ready load into an empty queue, serve it and check the extended result.
  task automatic do_load(input string tag, input op_t op, input logic [3:0] rob,
                         input logic [31:0] rs1, input logic [31:0] imm,
                         input logic [31:0] raw, input logic [31:0] exp_addr,
                         input logic [31:0] exp_val);
    push(op, rob, 1'b1, rs1, 1'b1, 32'h0, imm);
    tick();
    check({tag, " mc_req"}, 32'(bus.mc_req), 32'd1);
    check({tag, " mc_addr"}, bus.mc_addr, exp_addr);
    check({tag, " mc_op"}, 32'(bus.mc_op), 32'(op));
    bus.mc_done = 1'b1;
    bus.mc_data = raw;
    tick();
    bus.mc_done = 1'b0;
    check({tag, " res_valid"}, 32'(bus.res_valid), 32'd1);
    check({tag, " res_val"}, bus.res_val, exp_val);
    check({tag, " res_rob_id"}, 32'(bus.res_rob_id), 32'(rob));
    check({tag, " mc_req drop"}, 32'(bus.mc_req), 32'd0);
    check({tag, " empty"}, 32'(dut.count), 32'd0);
    tick();
    check({tag, " res pulse"}, 32'(bus.res_valid), 32'd0);
  endtask

  logic [3:0]  drain_rob [16];
  logic [31:0] drain_addr [16];

  initial begin
    clear_inputs();
    #12;
    check("reset full", 32'(bus.full), 32'd0);
    check("reset mc_req", 32'(bus.mc_req), 32'd0);
    check("reset res_valid", 32'(bus.res_valid), 32'd0);
    check("reset mc_addr", bus.mc_addr, 32'd0);
    check("reset res_val", bus.res_val, 32'd0);
    rst_n = 1'b1;
    rdy   = 1'b1;
    tick();

    do_load("lw", OP_LW, 4'd1, 32'h100, 32'h4, 32'hDEAD_BEEF, 32'h104, 32'hDEAD_BEEF);
    do_load("lb", OP_LB, 4'd2, 32'h10, 32'h0, 32'h0000_0080, 32'h10, 32'hFFFF_FF80);
    do_load("lbu", OP_LBU, 4'd3, 32'h10, 32'h0, 32'h0000_0080, 32'h10, 32'h0000_0080);
    do_load("lh", OP_LH, 4'd4, 32'h20, 32'h2, 32'hFFFF_8001, 32'h22, 32'hFFFF_8001);
    do_load("lhu", OP_LHU, 4'd5, 32'h20, 32'h2, 32'hFFFF_8001, 32'h22, 32'h0000_8001);
    do_load("wrap", OP_LW, 4'd6, 32'hFFFF_FFF0, 32'h20, 32'h1234_5678, 32'h10, 32'h1234_5678);

    // Store waiting on tag 5, woken by the commit broadcast.
    push(OP_SW, 4'd6, 1'b1, 32'h200, 1'b0, 32'd5, 32'h8);
    tick();
    check("st blocked", 32'(bus.res_valid), 32'd0);
    bus.rob_bc_valid = 1'b1;
    bus.rob_bc_id    = 4'd5;
    bus.rob_bc_val   = 32'd7;
    tick();
    bus.rob_bc_valid = 1'b0;
    check("st wake no early res", 32'(bus.res_valid), 32'd0);
    tick();
    check("st res_valid", 32'(bus.res_valid), 32'd1);
    check("st res_val", bus.res_val, 32'd7);
    check("st res_addr", bus.res_addr, 32'h208);
    check("st res_rob_id", 32'(bus.res_rob_id), 32'd6);
    tick();
    check("st res pulse", 32'(bus.res_valid), 32'd0);
    bus.head_store_commit  = 1'b1;
    bus.head_commit_rob_id = 4'd4;
    tick();
    check("st wrong commit", 32'(dut.count), 32'd1);
    bus.head_commit_rob_id = 4'd6;
    tick();
    bus.head_store_commit = 1'b0;
    check("st popped", 32'(dut.count), 32'd0);

    // Operand woken by a broadcast in the same cycle as its push.
    set_push(OP_LW, 4'd2, 1'b0, 32'd9, 1'b1, 32'h0, 32'h10);
    bus.rob_bc_valid = 1'b1;
    bus.rob_bc_id    = 4'd9;
    bus.rob_bc_val   = 32'h300;
    tick();
    bus.id_valid     = 1'b0;
    bus.rob_bc_valid = 1'b0;
    tick();
    check("push wake mc_req", 32'(bus.mc_req), 32'd1);
    check("push wake mc_addr", bus.mc_addr, 32'h310);
    bus.mc_done = 1'b1;
    bus.mc_data = 32'h55;
    tick();
    bus.mc_done = 1'b0;
    check("push wake res_val", bus.res_val, 32'h55);
    tick();

    // Second load's base comes from the first load's result bus.
    push(OP_LW, 4'd3, 1'b1, 32'h40, 1'b1, 32'h0, 32'h0);
    push(OP_LW, 4'd4, 1'b0, 32'd3, 1'b1, 32'h0, 32'h4);
    check("chain first addr", bus.mc_addr, 32'h40);
    bus.mc_done = 1'b1;
    bus.mc_data = 32'h1000;
    tick();
    bus.mc_done = 1'b0;
    check("chain first res", bus.res_val, 32'h1000);
    tick();
    check("chain wait", 32'(bus.mc_req), 32'd0);
    tick();
    check("chain second req", 32'(bus.mc_req), 32'd1);
    check("chain second addr", bus.mc_addr, 32'h1004);
    bus.mc_done = 1'b1;
    bus.mc_data = 32'h0;
    tick();
    bus.mc_done = 1'b0;
    check("chain second rob", 32'(bus.res_rob_id), 32'd4);
    tick();

    // Fill to the guard level, then push+pop, push while full, and a rejected push.
    for (int i = 0; i < 15; i++) begin
      push(OP_LW, 4'(i), 1'b0, 32'd15, 1'b1, 32'h0, 32'h0);
      if (i == 13) check("full at 14", 32'(bus.full), 32'd0);
    end
    check("full at 15", 32'(bus.full), 32'd1);
    check("count 15", 32'(dut.count), 32'd15);
    bus.rob_bc_valid = 1'b1;
    bus.rob_bc_id    = 4'd15;
    bus.rob_bc_val   = 32'h400;
    tick();
    bus.rob_bc_valid = 1'b0;
    tick();
    check("fill first req", 32'(bus.mc_req), 32'd1);
    check("fill first addr", bus.mc_addr, 32'h400);
    bus.mc_done = 1'b1;
    set_push(OP_LW, 4'd15, 1'b1, 32'h500, 1'b1, 32'h0, 32'h0);
    tick();
    bus.mc_done = 1'b0;
    check("push+pop count", 32'(dut.count), 32'd15);
    check("push+pop res rob", 32'(bus.res_rob_id), 32'd0);
    set_push(OP_LW, 4'd3, 1'b1, 32'h600, 1'b1, 32'h0, 32'h0);
    tick();
    check("push while full", 32'(dut.count), 32'd16);
    check("full at 16", 32'(bus.full), 32'd1);
    set_push(OP_LW, 4'd7, 1'b1, 32'h700, 1'b1, 32'h0, 32'h0);
    tick();
    bus.id_valid = 1'b0;
    check("push rejected", 32'(dut.count), 32'd16);
    for (int k = 0; k < 14; k++) begin
      drain_rob[k]  = 4'(k + 1);
      drain_addr[k] = 32'h400;
    end
    drain_rob[14] = 4'd15; drain_addr[14] = 32'h500;
    drain_rob[15] = 4'd3;  drain_addr[15] = 32'h600;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("drain%0d req", k), 32'(bus.mc_req), 32'd1);
      check($sformatf("drain%0d addr", k), bus.mc_addr, drain_addr[k]);
      bus.mc_done = 1'b1;
      bus.mc_data = 32'(k);
      tick();
      bus.mc_done = 1'b0;
      check($sformatf("drain%0d rob", k), 32'(bus.res_rob_id), 32'(drain_rob[k]));
      tick();
    end
    check("drain empty", 32'(dut.count), 32'd0);
    check("drain full", 32'(bus.full), 32'd0);

    // Rollback in LOAD_WAIT with completion the next cycle.
    push(OP_LW, 4'd1, 1'b1, 32'h40, 1'b1, 32'h0, 32'h0);
    tick();
    check("rb1 req", 32'(bus.mc_req), 32'd1);
    bus.rollback = 1'b1;
    tick();
    bus.rollback = 1'b0;
    bus.mc_done  = 1'b1;
    check("rb1 mc_req", 32'(bus.mc_req), 32'd0);
    check("rb1 count", 32'(dut.count), 32'd0);
    tick();
    bus.mc_done = 1'b0;
    check("rb1 no res", 32'(bus.res_valid), 32'd0);
    check("rb1 mc_req late", 32'(bus.mc_req), 32'd0);
    // Rollback and completion in the same cycle.
    push(OP_LW, 4'd2, 1'b1, 32'h40, 1'b1, 32'h0, 32'h0);
    tick();
    bus.rollback = 1'b1;
    bus.mc_done  = 1'b1;
    tick();
    bus.rollback = 1'b0;
    bus.mc_done  = 1'b0;
    check("rb2 no res", 32'(bus.res_valid), 32'd0);
    check("rb2 count", 32'(dut.count), 32'd0);
    check("rb2 mc_req", 32'(bus.mc_req), 32'd0);

    // rdy low freezes a pending completion.
    push(OP_LW, 4'd5, 1'b1, 32'h80, 1'b1, 32'h0, 32'h0);
    tick();
    rdy         = 1'b0;
    bus.mc_done = 1'b1;
    bus.mc_data = 32'h77;
    tick();
    tick();
    check("rdy0 no res", 32'(bus.res_valid), 32'd0);
    check("rdy0 hold req", 32'(bus.mc_req), 32'd1);
    rdy = 1'b1;
    tick();
    bus.mc_done = 1'b0;
    check("rdy1 res_valid", 32'(bus.res_valid), 32'd1);
    check("rdy1 res_val", bus.res_val, 32'h77);
    tick();

    // Asynchronous reset in the middle of a load.
    push(OP_LW, 4'd6, 1'b1, 32'h90, 1'b1, 32'h0, 32'h0);
    tick();
    check("ar pre req", 32'(bus.mc_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar mc_req", 32'(bus.mc_req), 32'd0);
    check("ar mc_addr", bus.mc_addr, 32'd0);
    check("ar mc_op", 32'(bus.mc_op), 32'd0);
    check("ar res_val", bus.res_val, 32'd0);
    check("ar res_rob_id", 32'(bus.res_rob_id), 32'd0);
    check("ar res_addr", bus.res_addr, 32'd0);
    check("ar count", 32'(dut.count), 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    check("ar after release", 32'(bus.mc_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
